// File: rtl/fpu_sched_pkg.sv
// Shared constants and types for the register-dependency scoreboard.
//   NUM_BLOCKS  : execution blocks that can retire a result per cycle
//   NUM_REGS    : architectural registers tracked
//   MAX_PENDING : in-flight writes allowed per register
// Derived widths, address/counter types and the signed next-count helper
// live here so the decoder and the top agree on them.
package fpu_sched_pkg;

  localparam int NUM_BLOCKS  = 6;
  localparam int NUM_REGS    = 16;
  localparam int MAX_PENDING = 3;

  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam int CNT_W  = $clog2(MAX_PENDING + 1);
  localparam int NCLR_W = $clog2(NUM_BLOCKS + 1);
  localparam int SUM_W  = CNT_W + NCLR_W;

  typedef logic [ADDR_W-1:0]        reg_addr_t;
  typedef logic [CNT_W-1:0]         pend_cnt_t;
  typedef logic [NCLR_W-1:0]        clr_cnt_t;
  typedef logic signed [SUM_W-1:0]  pend_sum_t;

  // count + inc - n_clr, wide enough that a multi-block retire on a small
  // count goes visibly negative instead of wrapping.
  function automatic pend_sum_t next_pending(input pend_cnt_t cnt,
                                             input logic      inc,
                                             input clr_cnt_t  n_clr);
    pend_sum_t s_cnt;
    pend_sum_t s_inc;
    pend_sum_t s_clr;
    s_cnt = pend_sum_t'({1'b0, cnt});
    s_inc = pend_sum_t'({1'b0, inc});
    s_clr = pend_sum_t'({1'b0, n_clr});
    return s_cnt + s_inc - s_clr;
  endfunction

endpackage

// File: rtl/dependency_scoreboard_clear_count_decode.sv
// Combinational retire decode: for every architectural register, counts how
// many execution blocks retire a write to it this cycle.
// Ports:
//   remove_enable  : per-block retire strobe
//   result_address : per-block retiring register, block i at [i*ADDR_W +: ADDR_W]
//   n_clr          : per-register number of retiring blocks (0..NUM_BLOCKS)
// Addresses >= NUM_REGS match no register and are silently dropped.
module clear_count_decode
  import fpu_sched_pkg::*;
(
  input  logic [NUM_BLOCKS-1:0]        remove_enable,
  input  logic [NUM_BLOCKS*ADDR_W-1:0] result_address,
  output clr_cnt_t [NUM_REGS-1:0]      n_clr
);

  always_comb begin
    n_clr = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        if (remove_enable[i] &&
            (result_address[i*ADDR_W +: ADDR_W] == reg_addr_t'(r))) begin
          n_clr[r] = n_clr[r] + clr_cnt_t'(1);
        end
      end
    end
  end

endmodule

// File: rtl/dependency_scoreboard.sv
// Register-dependency scoreboard between the scheduler and the execution
// blocks. Keeps a per-register count of in-flight writes, stalls issue on
// RAW/WAW hazards and pulses dependency_remove for one cycle when a
// register's last pending write retires.
// Ports:
//   clk, n_rst         : clock, async active-low reset
//   flush              : synchronous clear of all pending state (wins over all)
//   issue_valid/dest/src1/src2, issue_ready : issue handshake (ready is comb)
//   remove_enable, result_address           : per-block retire reports
//   busy               : count[r] != 0
//   dependency_remove  : one-cycle pulse when count[r] drops from nonzero to 0
//   err_underflow      : sticky, a retire hit a register with nothing pending
module dependency_scoreboard
  import fpu_sched_pkg::*;
(
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         flush,
  input  logic                         issue_valid,
  input  logic [ADDR_W-1:0]            issue_dest,
  input  logic [ADDR_W-1:0]            issue_src1,
  input  logic [ADDR_W-1:0]            issue_src2,
  output logic                         issue_ready,
  input  logic [NUM_BLOCKS-1:0]        remove_enable,
  input  logic [NUM_BLOCKS*ADDR_W-1:0] result_address,
  output logic [NUM_REGS-1:0]          busy,
  output logic [NUM_REGS-1:0]          dependency_remove,
  output logic                         err_underflow
);

  pend_cnt_t [NUM_REGS-1:0] count;
  pend_cnt_t [NUM_REGS-1:0] next_count;
  clr_cnt_t  [NUM_REGS-1:0] n_clr;
  logic      [NUM_REGS-1:0] release_now;
  logic                     underflow_now;
  logic                     issue_fire;
  pend_cnt_t                dest_cnt;
  pend_cnt_t                src1_cnt;
  pend_cnt_t                src2_cnt;

  clear_count_decode u_clear_count_decode (
    .remove_enable  (remove_enable),
    .result_address (result_address),
    .n_clr          (n_clr)
  );

  // Hazard check reads registered counts only, so a retire in this cycle
  // opens the gate one cycle later. Out-of-range registers read as idle.
  always_comb begin
    dest_cnt = '0;
    src1_cnt = '0;
    src2_cnt = '0;
    if (int'(issue_dest) < NUM_REGS) dest_cnt = count[issue_dest];
    if (int'(issue_src1) < NUM_REGS) src1_cnt = count[issue_src1];
    if (int'(issue_src2) < NUM_REGS) src2_cnt = count[issue_src2];
    issue_ready = !flush && (src1_cnt == '0) && (src2_cnt == '0) &&
                  (int'(dest_cnt) < MAX_PENDING);
  end

  assign issue_fire = issue_valid && issue_ready;

  always_comb begin
    pend_sum_t nxt;
    logic      inc;
    next_count    = count;
    release_now   = '0;
    underflow_now = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      inc = issue_fire && (issue_dest == reg_addr_t'(r));
      nxt = next_pending(count[r], inc, n_clr[r]);
      if (nxt < 0) begin
        next_count[r] = '0;
        underflow_now = 1'b1;
      end else if (nxt > pend_sum_t'(MAX_PENDING)) begin
        // Unreachable while issue_ready gates the dest count; kept as a
        // saturation guard so the counter can never wrap.
        next_count[r] = pend_cnt_t'(MAX_PENDING);
      end else begin
        next_count[r] = pend_cnt_t'(nxt);
      end
      // Only a genuine nonzero -> zero transition releases; underflow on an
      // already idle register does not.
      release_now[r] = (count[r] != '0) && (nxt <= 0);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count             <= '0;
      dependency_remove <= '0;
      err_underflow     <= 1'b0;
    end else if (flush) begin
      count             <= '0;
      dependency_remove <= '0;
      err_underflow     <= 1'b0;
    end else begin
      count             <= next_count;
      dependency_remove <= release_now;
      err_underflow     <= err_underflow | underflow_now;
    end
  end

  always_comb begin
    busy = '0;
    for (int r = 0; r < NUM_REGS; r++) busy[r] = (count[r] != '0);
  end

endmodule

// File: tb/tb_dependency_scoreboard.sv
module tb_dependency_scoreboard;
  import fpu_sched_pkg::*;

  logic                         clk = 1'b0;
  logic                         n_rst;
  logic                         flush;
  logic                         issue_valid;
  logic [ADDR_W-1:0]            issue_dest;
  logic [ADDR_W-1:0]            issue_src1;
  logic [ADDR_W-1:0]            issue_src2;
  logic                         issue_ready;
  logic [NUM_BLOCKS-1:0]        remove_enable;
  logic [NUM_BLOCKS*ADDR_W-1:0] result_address;
  logic [NUM_REGS-1:0]          busy;
  logic [NUM_REGS-1:0]          dependency_remove;
  logic                         err_underflow;

  int total = 0;
  int bad   = 0;

  dependency_scoreboard dut (
    .clk               (clk),
    .n_rst             (n_rst),
    .flush             (flush),
    .issue_valid       (issue_valid),
    .issue_dest        (issue_dest),
    .issue_src1        (issue_src1),
    .issue_src2        (issue_src2),
    .issue_ready       (issue_ready),
    .remove_enable     (remove_enable),
    .result_address    (result_address),
    .busy              (busy),
    .dependency_remove (dependency_remove),
    .err_underflow     (err_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush          = 1'b0;
    issue_valid    = 1'b0;
    issue_dest     = '0;
    issue_src1     = '0;
    issue_src2     = '0;
    remove_enable  = '0;
    result_address = '0;
  endtask

  task automatic set_issue(input int dest, input int s1, input int s2);
    issue_valid = 1'b1;
    issue_dest  = ADDR_W'(dest);
    issue_src1  = ADDR_W'(s1);
    issue_src2  = ADDR_W'(s2);
  endtask

  task automatic set_ret(input int blk, input int addr);
    remove_enable[blk] = 1'b1;
    result_address[blk*ADDR_W +: ADDR_W] = ADDR_W'(addr);
  endtask

  task automatic probe_ready(input string tag, input int dest, input int s1,
                             input int s2, input logic exp);
    issue_dest = ADDR_W'(dest);
    issue_src1 = ADDR_W'(s1);
    issue_src2 = ADDR_W'(s2);
    #1;
    chk(tag, 32'(issue_ready), 32'(exp));
  endtask

  initial begin
    idle_inputs();
    n_rst = 1'b0;
    #2;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_dep", 32'(dependency_remove), 32'h0);
    chk("rst_err", 32'(err_underflow), 32'h0);
    step();
    step();
    n_rst = 1'b1;
    step();

    // 1. idle
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_dep", 32'(dependency_remove), 32'h0);
    probe_ready("idle_rdy_a", 0, 0, 0, 1'b1);
    probe_ready("idle_rdy_b", 15, 14, 13, 1'b1);

    // 2. single write to r5, RAW stall, retire by block 2
    set_issue(5, 0, 0);
    #1 chk("t2_rdy_pre", 32'(issue_ready), 32'h1);
    step();
    idle_inputs();
    chk("t2_busy", 32'(busy), 32'h0020);
    probe_ready("t2_raw_src1", 0, 5, 0, 1'b0);
    probe_ready("t2_raw_src2", 0, 0, 5, 1'b0);
    probe_ready("t2_waw_ok", 5, 0, 0, 1'b1);
    set_ret(2, 5);
    probe_ready("t2_no_bypass", 0, 5, 0, 1'b0);
    step();
    remove_enable = '0;
    chk("t2_dep", 32'(dependency_remove), 32'h0020);
    chk("t2_busy_clr", 32'(busy), 32'h0);
    probe_ready("t2_rdy_after", 0, 5, 0, 1'b1);
    step();
    chk("t2_dep_once", 32'(dependency_remove), 32'h0);

    // 3. saturate r3, stall on WAW limit, three blocks retire together
    set_issue(3, 0, 0);
    step();
    step();
    probe_ready("t3_cnt2_rdy", 3, 0, 0, 1'b1);
    step();
    chk("t3_busy", 32'(busy), 32'h0008);
    probe_ready("t3_full", 3, 0, 0, 1'b0);
    step();
    issue_valid = 1'b0;
    set_ret(0, 3);
    set_ret(1, 3);
    set_ret(4, 3);
    step();
    idle_inputs();
    chk("t3_dep", 32'(dependency_remove), 32'h0008);
    chk("t3_busy_clr", 32'(busy), 32'h0);
    chk("t3_no_err", 32'(err_underflow), 32'h0);
    step();
    chk("t3_dep_once", 32'(dependency_remove), 32'h0);

    // 4. issue and retire on r7 in the same cycle
    set_issue(7, 0, 0);
    step();
    chk("t4_busy1", 32'(busy), 32'h0080);
    set_issue(7, 0, 0);
    set_ret(1, 7);
    #1 chk("t4_rdy", 32'(issue_ready), 32'h1);
    step();
    idle_inputs();
    chk("t4_busy_net", 32'(busy), 32'h0080);
    chk("t4_no_dep", 32'(dependency_remove), 32'h0);
    set_ret(0, 7);
    step();
    idle_inputs();
    chk("t4_dep", 32'(dependency_remove), 32'h0080);
    chk("t4_busy_clr", 32'(busy), 32'h0);

    // 5. underflow on idle r9, sticky, cleared by flush
    set_ret(5, 9);
    step();
    idle_inputs();
    chk("t5_err", 32'(err_underflow), 32'h1);
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_no_dep", 32'(dependency_remove), 32'h0);
    step();
    chk("t5_sticky", 32'(err_underflow), 32'h1);
    flush = 1'b1;
    probe_ready("t5_flush_rdy", 0, 0, 0, 1'b0);
    step();
    flush = 1'b0;
    chk("t5_err_clr", 32'(err_underflow), 32'h0);

    // 6. flush with pending work, then async reset mid-run
    set_issue(1, 0, 0);
    step();
    set_issue(2, 0, 0);
    step();
    idle_inputs();
    chk("t6_busy", 32'(busy), 32'h0006);
    flush = 1'b1;
    set_issue(4, 0, 0);
    set_ret(0, 1);
    set_ret(3, 2);
    step();
    idle_inputs();
    chk("t6_flush_busy", 32'(busy), 32'h0);
    chk("t6_flush_dep", 32'(dependency_remove), 32'h0);
    step();
    chk("t6_flush_dep2", 32'(dependency_remove), 32'h0);
    chk("t6_flush_busy2", 32'(busy), 32'h0);
    set_issue(6, 0, 0);
    step();
    set_issue(8, 0, 0);
    step();
    idle_inputs();
    chk("t6_busy2", 32'(busy), 32'h0140);
    set_ret(0, 6);
    set_ret(3, 9);
    step();
    idle_inputs();
    chk("t6_dep", 32'(dependency_remove), 32'h0040);
    chk("t6_busy3", 32'(busy), 32'h0100);
    chk("t6_err", 32'(err_underflow), 32'h1);
    #2 n_rst = 1'b0;
    #1;
    chk("t6_arst_busy", 32'(busy), 32'h0);
    chk("t6_arst_dep", 32'(dependency_remove), 32'h0);
    chk("t6_arst_err", 32'(err_underflow), 32'h0);
    step();
    n_rst = 1'b1;
    step();
    chk("t6_post_busy", 32'(busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
